// File: rtl/serializer_stream_pkg.sv
// Shared types and helpers for the streaming bit serializer.
// Length decode turns the raw bit-count modifier into a length and a drop flag.
package serializer_stream_pkg;

   localparam int unsigned DEF_MIN_LEN = 3;

   typedef enum logic {
      IDLE_S,
      SHIFT_S
   } ser_state_t;

   typedef struct packed {
      logic        drop;
      int unsigned len;
   } len_dec_t;

   // A modifier of 0 selects a full word; short non-zero counts are discarded.
   function automatic len_dec_t decode_len(input int unsigned mod,
                                           input int unsigned data_w,
                                           input int unsigned min_len);
      len_dec_t r;
      r.len  = (mod == 0) ? data_w : mod;
      r.drop = (mod != 0) && (mod < min_len);
      return r;
   endfunction

endpackage

// File: rtl/serializer_stream_if.sv
// Word-in / bit-out handshake bundle between the word producer and the serial line driver.
interface serializer_stream_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MOD_W  = $clog2(DATA_W)
);
   logic [DATA_W-1:0] data_i;
   logic [MOD_W-1:0]  data_mod_i;
   logic              data_val_i;
   logic              busy_o;
   logic              ser_data_o;
   logic              ser_data_val_o;
   logic              ser_ready_i;

   modport master (
      output data_i, data_mod_i, data_val_i, ser_ready_i,
      input  busy_o, ser_data_o, ser_data_val_o
   );

   modport slave (
      input  data_i, data_mod_i, data_val_i, ser_ready_i,
      output busy_o, ser_data_o, ser_data_val_o
   );
endinterface

// File: rtl/serializer_stream_shift_unit.sv
// Shift register plus remaining-bit counter; the head bit is always the serial output.
// Shifting in zeros and clearing on the final bit keeps the output at 0 once idle.
module ser_shift_unit #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MOD_W     = $clog2(DATA_W),
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic [MOD_W:0]    len_i,
   input  logic              step_i,
   output logic              bit_o,
   output logic              last_o
);
   localparam logic [MOD_W:0] CNT_ONE = {{MOD_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [MOD_W:0]    cnt_q, cnt_d;

   assign last_o = (cnt_q == CNT_ONE);
   assign bit_o  = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];

   // A load wins over a step so the next word can replace the finishing one.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = word_i;
         cnt_d  = len_i;
      end else if (step_i) begin
         if (last_o) begin
            sreg_d = '0;
            cnt_d  = '0;
         end else begin
            sreg_d = MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
            cnt_d  = cnt_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/serializer_stream.sv
// Parametrised serializer: accept/drop logic, one-word hold stage, busy flag and shifter FSM.
//   state   | meaning
//   IDLE_S  | shifter empty, ser_data_val_o low
//   SHIFT_S | shifter holds a word with at least one bit left
module serializer_stream
   import serializer_stream_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MOD_W     = $clog2(DATA_W),
   parameter int unsigned MIN_LEN   = DEF_MIN_LEN,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                clk_i,
   input  logic                arst_ni,
   serializer_stream_if.slave  bus
);
   typedef logic [MOD_W:0] cnt_t;

   ser_state_t        state_q;
   logic              busy_q;
   logic [DATA_W-1:0] hold_data_q;
   cnt_t              hold_len_q;

   len_dec_t          dec;
   cnt_t              in_len;
   logic              accept, keep, xfer, last_bit, last_xfer;
   logic              to_shift, to_hold, reload, load;
   logic [DATA_W-1:0] load_data;
   cnt_t              load_len;
   logic              ser_bit;

   assign dec    = decode_len(32'(bus.data_mod_i), DATA_W, MIN_LEN);
   assign in_len = cnt_t'(dec.len);

   assign accept    = bus.data_val_i & ~busy_q;
   assign keep      = accept & ~dec.drop;
   assign xfer      = (state_q == SHIFT_S) & bus.ser_ready_i;
   assign last_xfer = xfer & last_bit;

   // Accept implies hold is empty, so a finishing shifter can take the new word directly.
   assign to_shift  = keep & ((state_q == IDLE_S) | last_xfer);
   assign to_hold   = keep & ~to_shift;
   assign reload    = last_xfer & busy_q;
   assign load      = to_shift | reload;
   assign load_data = busy_q ? hold_data_q : bus.data_i;
   assign load_len  = busy_q ? hold_len_q  : in_len;

   ser_shift_unit #(
      .DATA_W   (DATA_W),
      .MOD_W    (MOD_W),
      .MSB_FIRST(MSB_FIRST)
   ) u_shift (
      .clk_i  (clk_i),
      .arst_ni(arst_ni),
      .load_i (load),
      .word_i (load_data),
      .len_i  (load_len),
      .step_i (xfer),
      .bit_o  (ser_bit),
      .last_o (last_bit)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q     <= IDLE_S;
         busy_q      <= 1'b0;
         hold_data_q <= '0;
         hold_len_q  <= '0;
      end else begin
         case (state_q)
            IDLE_S:  if (load) state_q <= SHIFT_S;
            SHIFT_S: if (last_xfer && !load) state_q <= IDLE_S;
            default: state_q <= IDLE_S;
         endcase
         if (to_hold) begin
            hold_data_q <= bus.data_i;
            hold_len_q  <= in_len;
            busy_q      <= 1'b1;
         end else if (reload) begin
            busy_q      <= 1'b0;
         end
      end
   end

   assign bus.busy_o         = busy_q;
   assign bus.ser_data_val_o = (state_q == SHIFT_S);
   assign bus.ser_data_o     = ser_bit;
endmodule

// File: doc/serializer_stream.md
# serializer_stream

Parametrised bit serializer: accepts a parallel word of `DATA_W` bits with a bit-count modifier and emits it one bit per cycle, MSB-first or LSB-first. It is the successor of the fixed 16-bit serializer in the same link datapath. New behaviour:
- generic width;
- output backpressure via `ser_ready_i`;
- a one-word holding register, so consecutive words stream with no idle bit between them.

It sits between the word-level producer and the serial line driver.

## Interface
- `DATA_W`, 16, parallel word width; ≥ 4, power of two.
- `MOD_W`, `$clog2(DATA_W)`, width of `data_mod_i`.
- `MIN_LEN`, 3, smallest accepted non-zero bit count; counts 1..`MIN_LEN`-1 are dropped.
- `MSB_FIRST`, 1, 1: transmit from `data_i[DATA_W-1]` downward; 0: from `data_i[0]` upward.

Ports:
- `clk_i` input 1: single clock, all logic on the rising edge.
- `arst_ni` input 1: reset, asynchronous and active-low.
- `data_i` input `DATA_W`: parallel word.
- `data_mod_i` input `MOD_W`: number of bits to send; 0 means `DATA_W`.
- `data_val_i` input 1: word valid.
- `busy_o` output 1: cannot accept; `data_val_i` is ignored while high.
- `ser_data_o` output 1: serial bit.
- `ser_data_val_o` output 1: `ser_data_o` valid.
- `ser_ready_i` input 1: sink accepts the current bit.

## Operation
- **Accept:** a word is accepted at an edge where `data_val_i`=1 and `busy_o`=0.
  - Length L = `DATA_W` if `data_mod_i`=0, else `data_mod_i`.
  - If 0 < `data_mod_i` < `MIN_LEN`, the word is consumed and discarded: no output, no state change.
- **Bit selection:**
  - `MSB_FIRST`=1: bits `DATA_W`-1 down to `DATA_W`-L.
  - `MSB_FIRST`=0: bits 0 up to L-1.
- **Two storage stages:**
  - Shifter: active word, shift register plus remaining-bit counter.
  - Hold: one pending word with its length.
- **Routing:**
  - An accepted word goes to the shifter if the shifter is idle, or if it is finishing its last bit in that same cycle and hold is empty.
  - Otherwise it goes to hold.
- **Bit transfer:** a bit transfers at an edge where `ser_data_val_o`=1 and `ser_ready_i`=1.
  - On transfer the shifter advances and the counter decrements.
  - With `ser_ready_i`=0, `ser_data_o`/`ser_data_val_o` hold stable.
- **Last bit:** on transfer of the last bit (counter=1):
  - if hold is full, hold moves to the shifter at the same edge;
  - else the shifter goes idle.
- **State machine** (per shifter):
  - IDLE → SHIFT on load.
  - SHIFT → SHIFT on last-bit transfer with a reload available.
  - SHIFT → IDLE on last-bit transfer with nothing pending.
- **`busy_o`:** registered; 1 exactly when hold is full.
- **Reset:**
  - Async assertion at any time, mid-word included: the in-flight and held words are discarded, state goes to IDLE, and all outputs go to 0 immediately.
  - Reset values: `busy_o`=0, `ser_data_o`=0, `ser_data_val_o`=0.
- **Counter:** `MOD_W`+1 bits, so L=`DATA_W` is representable; no wrap-around.
- **`ser_data_o` when idle:** 0 whenever `ser_data_val_o`=0.

## Timing
- All outputs are registered.
- Latency: word accepted at edge N with the shifter idle → first bit visible after edge N, `ser_data_val_o`=1 in cycle N+1.
- With `ser_ready_i` held at 1, a word of L bits occupies exactly L consecutive valid cycles.
- Back-to-back: with hold full at the last-bit edge, the next word's first bit follows immediately, with zero idle cycles.
- `busy_o` rises the cycle after a word lands in hold.
- `busy_o` falls the cycle after hold moves to the shifter.
- A word offered in the same cycle that hold drains is not accepted; `busy_o` was still 1 in that cycle.
- Simultaneous accept and last-bit transfer with hold empty: the new word loads straight into the shifter, with no gap.

## Structure
- Package `serializer_stream_pkg`:
  - state enum `ser_state_t` {IDLE_S, SHIFT_S};
  - length-decode function (mod → L, drop flag);
  - default `MIN_LEN` constant.
- Sub-module `ser_shift_unit`:
  - holds the shift register, remaining-bit counter and direction select;
  - takes a load pulse with word/length and a step input;
  - reports a last-bit flag.
- Top level: accept logic, hold register, `busy_o`, and the state machine.

## Test plan
- **Full word:** `DATA_W`=16, `data_i`=16'hA5C3, mod=0, ready=1 → 16 valid cycles of 1010_0101_1100_0011 starting at N+1, then `ser_data_val_o`=0.
- **Short word and drops:**
  - mod=5, `data_i`=16'hF800, `MSB_FIRST`=1 → bits 1,1,1,1,1, then idle.
  - mod=1 and mod=2 → no output, `busy_o` stays 0.
- **LSB-first build:** `MSB_FIRST`=0, `data_i`=16'h0006, mod=4 → 0,1,1,0.
- **Streaming:** two words of 4 bits, the second offered while the first shifts → `busy_o` pulses, 8 contiguous valid cycles; a third word offered while `busy_o`=1 is ignored.
- **Backpressure:** deassert `ser_ready_i` for 3 cycles mid-word → bit held stable for 3 cycles, total valid cycles = L+3, sequence unchanged.
- **Reset mid-word:** assert `arst_ni`=0 after bit 7 of a 16-bit word, between clock edges → outputs 0 immediately; after release, idle with `busy_o`=0; the next word serializes correctly.
